uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: pops words from the TX FIFO and serialises each onto `o_tx` as start bit, LSB-first data, optional parity, and 1 or 2 stop bits. It is the transmit counterpart of the UART receiver. It shares the external baud prescaler and its strobe convention, and sits between the TX FIFO read port and the pad.

## Interface
Parameters:
- `Parity`, 1'b0: 1 = append parity bit, 0 = none
- `ParityOdd`, 1'b0: 1 = odd parity, 0 = even (ignored when `Parity`=0)
- `StopBits`, 1: number of stop bits, legal values 1 or 2
- `DataLength`, 8: data bits per frame, legal range 5..9

Ports:
- `i_clk` in 1: clock at baudrate × oversampling
- `i_rst_n` in 1: reset, asynchronous, active-low
- `i_fifo_data` in `DataLength`: FIFO head word, first-word-fall-through, valid while `!i_fifo_empty`
- `i_fifo_empty` in 1: TX FIFO empty
- `o_fifo_read_en` out 1: one-cycle pop pulse
- `i_strobe` in 1: one-cycle pulse from prescaler at end of each bit period
- `o_prescaler_en` out 1: prescaler run enable; prescaler clears while low
- `o_tx` out 1: serial line, idle high
- `o_busy` out 1: high in every state except IDLE

## Operation
- States: IDLE, LOAD, START, DATA, PARITY, STOP; BREAK is added with the macro.
- IDLE: `o_tx`=1. If `!i_fifo_empty` → LOAD.
- LOAD, exactly 1 cycle:
  - `o_fifo_read_en`=1.
  - Shift register ← `i_fifo_data`.
  - Parity bit ← `^i_fifo_data ^ ParityOdd`.
  - → START.
- START: `o_tx`=0. On `i_strobe`: bit counter ← `DataLength-1`, → DATA.
- DATA: `o_tx`=shift_reg[0]. On `i_strobe`: shift right. If counter==0 → PARITY if `Parity`, else STOP. Otherwise decrement the counter.
- PARITY: `o_tx`=parity bit. On `i_strobe` → STOP.
- STOP: `o_tx`=1. Stop counter starts at `StopBits-1`. On `i_strobe` with counter==0 → IDLE; otherwise decrement.
- `o_prescaler_en`=1 in START, DATA, PARITY, STOP (and BREAK); 0 in IDLE and LOAD.
- `i_strobe` is ignored in IDLE and LOAD.
- Counters are `$clog2(DataLength)` bits wide and never wrap; transitions occur at 0.
- `i_fifo_empty` is not sampled outside IDLE. A word written mid-frame is sent in the next frame.

## Timing
- Reset values: `o_tx`=1, `o_fifo_read_en`=0, `o_prescaler_en`=0, `o_busy`=0, state=IDLE, shift register=0.
- `o_tx` is a flop, loaded on the same edge as the state change, so it is glitch-free.
- Latency: FIFO non-empty at edge N → LOAD at N+1 → START, `o_tx` falls at N+2.
- Each bit lasts from state entry to its terminating strobe: `Oversample` cycles with a prescaler cleared on enable.
- Frame duration = 2 + (1 + `DataLength` + `Parity` + `StopBits`) × bit period cycles.
- Back-to-back frames: STOP → IDLE → LOAD adds 2 idle-high cycles between frames, which is acceptable.
- Reset mid-frame: `o_tx` returns high asynchronously and the popped word is discarded, not re-read.

## Configuration
- `UART_TX_BREAK_EN` defined: adds input `i_break` and state BREAK.
  - In IDLE, `i_break`=1 takes priority over the FIFO → BREAK.
  - BREAK holds `o_tx`=0 with the prescaler running until `i_break`=0 is seen on a strobe, then → STOP, giving `StopBits` of mark.
- Not defined: the port and state are absent, and `i_break` behaviour does not exist.

## Structure
- Shared `uart_pkg`: `tx_states_t` enum (3-bit) and the legal `DataLength`/`StopBits` range constants, shared with the receiver.
- Parity is a reduction XOR inline, so no sub-module is needed.
- The prescaler stays the existing external block.

## Test plan
- 8N1, oversample 16, FIFO word 0x55 → `o_tx` = 0,1,0,1,0,1,0,1,0,1, each exactly 16 cycles; one `o_fifo_read_en` pulse; `o_busy` drops after the stop bit.
- `Parity`=1, even, 0x07 → parity bit 1 after data. With `ParityOdd`=1 → parity bit 0.
- `StopBits`=2, FIFO holding 0xA3 then 0x3C → two stop periods of 16 cycles, then 2 idle cycles, then the second start bit; exactly two pops.
- `DataLength`=5, word 5'b10011 → 5 data bits 1,1,0,0,1 LSB first, then stop.
- Reset asserted during DATA bit 3 → `o_tx`=1 immediately. After release, no pop occurs until FIFO non-empty, and the next frame starts cleanly.
- With `UART_TX_BREAK_EN`: `i_break` held for 40 cycles in IDLE while FIFO non-empty → `o_tx` low until the strobe after release, then stop bits, then the FIFO word is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and legal configuration ranges
//
// Shared by the UART transmitter and receiver.
// Contents:
//   tx_states_t   - 3-bit transmitter state encoding (TX_BREAK only with UART_TX_BREAK_EN)
//   DATA_LENGTH_* - legal data bits per frame
//   STOP_BITS_*   - legal stop bit count
//   uart_cfg_legal - true when a DataLength/StopBits pair is inside the legal ranges

package uart_pkg;

  localparam int unsigned DATA_LENGTH_MIN = 5;
  localparam int unsigned DATA_LENGTH_MAX = 9;
  localparam int unsigned STOP_BITS_MIN   = 1;
  localparam int unsigned STOP_BITS_MAX   = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_LOAD   = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5
`ifdef UART_TX_BREAK_EN
    ,
    TX_BREAK  = 3'd6
`endif
  } tx_states_t;

  function automatic bit uart_cfg_legal(input int unsigned data_length,
                                        input int unsigned stop_bits);
    return (data_length >= DATA_LENGTH_MIN) && (data_length <= DATA_LENGTH_MAX) &&
           (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter between the TX FIFO read port and the pad
//
// Pops one word from a first-word-fall-through FIFO and sends it as
// start bit, LSB-first data, optional parity and 1 or 2 stop bits.
// Bit timing comes from an external prescaler: it runs while o_prescaler_en
// is high (cleared while low) and pulses i_strobe at the end of each bit.
//
// Parameters:
//   Parity     - 1: append parity bit
//   ParityOdd  - 1: odd parity, 0: even
//   StopBits   - 1 or 2
//   DataLength - data bits per frame, 5..9
// Ports:
//   i_clk          - clock at baudrate x oversampling
//   i_rst_n        - asynchronous active-low reset
//   i_fifo_data    - FIFO head word, valid while !i_fifo_empty
//   i_fifo_empty   - TX FIFO empty
//   o_fifo_read_en - one-cycle pop pulse
//   i_strobe       - end-of-bit pulse from the prescaler
//   o_prescaler_en - prescaler run enable
//   o_tx           - serial line, idle high, registered
//   o_busy         - high whenever not idle
//   i_break        - (UART_TX_BREAK_EN only) hold line low while high
//
// Build option: define UART_TX_BREAK_EN to add i_break and the break state.

module uart_tx
  import uart_pkg::*;
#(
  parameter bit          Parity     = 1'b0,
  parameter bit          ParityOdd  = 1'b0,
  parameter int unsigned StopBits   = 1,
  parameter int unsigned DataLength = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DataLength-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_read_en,
  input  logic                  i_strobe,
  output logic                  o_prescaler_en,
  output logic                  o_tx,
  output logic                  o_busy
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                  i_break
`endif
);

  localparam int unsigned CntW = $clog2(DataLength);
  localparam logic [CntW-1:0] DataLast = CntW'(DataLength - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(StopBits - 1);

  tx_states_t            state_q, state_d;
  logic [DataLength-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_d;

  // One counter serves both the data bits and the stop bits; it is
  // reloaded on every entry to DATA or STOP and only counts down to zero.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    parity_d       = parity_q;
    o_fifo_read_en = 1'b0;
    o_prescaler_en = 1'b0;
    o_busy         = 1'b1;

    case (state_q)
      TX_IDLE: begin
        o_busy = 1'b0;
`ifdef UART_TX_BREAK_EN
        if (i_break) begin
          state_d = TX_BREAK;
        end else if (!i_fifo_empty) begin
          state_d = TX_LOAD;
        end
`else
        if (!i_fifo_empty) begin
          state_d = TX_LOAD;
        end
`endif
      end

      TX_LOAD: begin
        o_fifo_read_en = 1'b1;
        shift_d        = i_fifo_data;
        parity_d       = (^i_fifo_data) ^ ParityOdd;
        state_d        = TX_START;
      end

      TX_START: begin
        o_prescaler_en = 1'b1;
        if (i_strobe) begin
          cnt_d   = DataLast;
          state_d = TX_DATA;
        end
      end

      TX_DATA: begin
        o_prescaler_en = 1'b1;
        if (i_strobe) begin
          shift_d = shift_q >> 1;
          if (cnt_q == '0) begin
            if (Parity) begin
              state_d = TX_PARITY;
            end else begin
              cnt_d   = StopLast;
              state_d = TX_STOP;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      TX_PARITY: begin
        o_prescaler_en = 1'b1;
        if (i_strobe) begin
          cnt_d   = StopLast;
          state_d = TX_STOP;
        end
      end

      TX_STOP: begin
        o_prescaler_en = 1'b1;
        if (i_strobe) begin
          if (cnt_q == '0) begin
            state_d = TX_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      // Release is only honoured on a bit boundary so the low period is a
      // whole number of bit times, followed by normal stop bits.
      TX_BREAK: begin
        o_prescaler_en = 1'b1;
        if (i_strobe && !i_break) begin
          cnt_d   = StopLast;
          state_d = TX_STOP;
        end
      end
`endif

      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so the o_tx flop changes on
  // the same edge as the state register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
      TX_PARITY: tx_d = parity_d;
`ifdef UART_TX_BREAK_EN
      TX_BREAK:  tx_d = 1'b0;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= TX_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      o_tx     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      o_tx     <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx in four configurations
`timescale 1ns/1ps

module tb_uart_tx;

  localparam int NU = 4;
  // u0: 8N1, u1: 8E1, u2: 8O2, u3: 5N1
  localparam int P_PAR  [NU] = '{0, 1, 1, 0};
  localparam int P_ODD  [NU] = '{0, 0, 1, 0};
  localparam int P_STOP [NU] = '{1, 1, 2, 1};
  localparam int P_DL   [NU] = '{8, 8, 8, 5};

  typedef struct {
    logic [12:0] bits;
    int          nbits;
    int          gap;
    bit          abort;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NU-1:0] tx, busy, rd, pen, strobe;
  logic [NU-1:0] empty = '1;
  logic [NU-1:0] brk   = '0;
  logic [8:0]    fdata [NU];
  logic [3:0]    pcnt  [NU];
  logic [NU-1:0] pop_pend = '0;
  int            pops     [NU];
  int            exp_pops [NU];
  logic [8:0]    fifo_q [NU][$];
  frame_t        exp_q  [NU][$];
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    uart_tx #(
      .Parity    (P_PAR[g] != 0),
      .ParityOdd (P_ODD[g] != 0),
      .StopBits  (P_STOP[g]),
      .DataLength(P_DL[g])
    ) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_fifo_data   (fdata[g][P_DL[g]-1:0]),
      .i_fifo_empty  (empty[g]),
      .o_fifo_read_en(rd[g]),
      .i_strobe      (strobe[g]),
      .o_prescaler_en(pen[g]),
      .o_tx          (tx[g]),
      .o_busy        (busy[g])
`ifdef UART_TX_BREAK_EN
      ,
      .i_break       (brk[g])
`endif
    );

    // Prescaler model: oversample 16, cleared while disabled.
    assign strobe[g] = pen[g] && (pcnt[g] == 4'd15);
  end

  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) pcnt[u] <= pen[u] ? pcnt[u] + 4'd1 : 4'd0;
  end

  // FWFT FIFO model: outputs change only on negedges; a pop seen during
  // LOAD takes effect at the following negedge.
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (pop_pend[u]) begin
        if (fifo_q[u].size() > 0) void'(fifo_q[u].pop_front());
        pops[u]++;
      end
      pop_pend[u] = rd[u];
      empty[u]    = (fifo_q[u].size() == 0);
      fdata[u]    = (fifo_q[u].size() > 0) ? fifo_q[u][0] : 9'h0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic frame_t build(input int u, input logic [8:0] w, input int gap, input bit ab);
    frame_t f;
    logic   p;
    int     n;
    f.bits = '0;
    n      = 1;                     // bit 0 is the start bit (0)
    p      = (P_ODD[u] != 0);
    for (int i = 0; i < P_DL[u]; i++) begin
      f.bits[n] = w[i];
      p         = p ^ w[i];
      n++;
    end
    if (P_PAR[u] != 0) begin
      f.bits[n] = p;
      n++;
    end
    for (int i = 0; i < P_STOP[u]; i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = n;
    f.gap   = gap;
    f.abort = ab;
    return f;
  endfunction

  task automatic push(input int u, input logic [8:0] w, input int gap, input bit ab);
    fifo_q[u].push_back(w);
    exp_q[u].push_back(build(u, w, gap, ab));
    exp_pops[u]++;
  endtask

  task automatic wait_idle(input int bound);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
      done = (busy == '0);
      for (int u = 0; u < NU; u++)
        if (exp_q[u].size() != 0 || fifo_q[u].size() != 0) done = 0;
    end
    if (!done) check("wait_idle_timeout", 0, 1);
  endtask

  // Monitors: on a falling line, pop the expected frame and check the first
  // and last cycle of every 16-cycle bit, then the return to idle.
  for (genvar g = 0; g < NU; g++) begin : g_mon
    initial begin
      frame_t f;
      int     idle;
      int     n;
      bit     ab;
      idle = 1000;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          idle = 1000;
        end else if (tx[g] == 1'b0) begin
          if (exp_q[g].size() == 0) begin
            check($sformatf("u%0d_unexpected_start", g), 1, 0);
            n = 0;
            while (tx[g] == 1'b0 && n < 500) begin
              @(negedge clk);
              n++;
            end
            idle = 1000;
          end else begin
            f  = exp_q[g].pop_front();
            ab = 0;
            if (f.gap >= 0) check($sformatf("u%0d_gap", g), idle, f.gap);
            for (int b = 0; b < f.nbits && !ab; b++) begin
              for (int c = 0; c < 16; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (!rst_n) begin
                  ab = 1;
                  break;
                end
                if (c == 0 || c == 15)
                  check($sformatf("u%0d_bit%0d_c%0d", g, b, c), tx[g], f.bits[b]);
              end
            end
            check($sformatf("u%0d_abort", g), ab, f.abort);
            if (!ab) begin
              @(negedge clk);
              check($sformatf("u%0d_end_busy", g), busy[g], 0);
              check($sformatf("u%0d_end_tx", g), tx[g], 1);
              idle = 1;
            end else begin
              idle = 1000;
            end
          end
        end else begin
          idle++;
        end
      end
    end
  end

  initial begin
    int n;
    frame_t fb;
    for (int u = 0; u < NU; u++) begin
      pops[u]     = 0;
      exp_pops[u] = 0;
      pcnt[u]     = 4'd0;
      fdata[u]    = 9'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check($sformatf("u%0d_rst_tx", u), tx[u], 1);
      check($sformatf("u%0d_rst_rd", u), rd[u], 0);
      check($sformatf("u%0d_rst_pen", u), pen[u], 0);
      check($sformatf("u%0d_rst_busy", u), busy[u], 0);
    end
    rst_n = 1'b1;

    // Main frames on all four configurations in parallel.
    @(posedge clk);
    push(0, 9'h055, -1, 0);
    push(1, 9'h007, -1, 0);
    push(1, 9'h000, 2, 0);
    push(2, 9'h0A3, -1, 0);
    push(2, 9'h03C, 2, 0);
    push(2, 9'h007, 2, 0);
    push(3, 9'h013, -1, 0);
    wait_idle(3000);

    // Reset in data bit 3 of 0xF0 (a 0 bit), popped word is discarded.
    @(posedge clk);
    push(0, 9'h0F0, -1, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx[0] !== 1'b0 && n < 100);
    check("rst_frame_start", tx[0], 0);
    repeat (70) @(negedge clk);
    check("rst_pre_tx", tx[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", tx[0], 1);
    check("rst_async_busy", busy[0], 0);
    check("rst_async_pen", pen[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_repop", pops[0], exp_pops[0]);
    check("rst_idle_busy", busy[0], 0);
    check("rst_idle_tx", tx[0], 1);

    // Start latency after reset: LOAD one cycle after non-empty, start bit next.
    @(posedge clk);
    push(0, 9'h0C3, -1, 0);
    @(negedge clk);
    check("lat_idle_rd", rd[0], 0);
    @(negedge clk);
    check("lat_load_rd", rd[0], 1);
    check("lat_load_tx", tx[0], 1);
    check("lat_load_busy", busy[0], 1);
    @(negedge clk);
    check("lat_start_tx", tx[0], 0);
    check("lat_start_rd", rd[0], 0);
    wait_idle(1000);

`ifdef UART_TX_BREAK_EN
    // Break held ~40 cycles: low until the strobe after release (3 bits),
    // one stop bit, then the queued word after two idle cycles.
    @(posedge clk);
    fb.bits  = 13'b0_0000_0000_1000;
    fb.nbits = 4;
    fb.gap   = -1;
    fb.abort = 0;
    exp_q[0].push_back(fb);
    push(0, 9'h05A, 2, 0);
    @(negedge clk);
    brk[0] = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    brk[0] = 1'b0;
    wait_idle(1000);
`endif

    for (int u = 0; u < NU; u++) check($sformatf("u%0d_pops", u), pops[u], exp_pops[u]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
